// File: rtl/square_animator_pkg.sv
// Shared screen geometry, colour table and start-position helpers for the
// bouncing-square animator.
package square_animator_pkg;

  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int C_W   = 11;

  typedef logic [C_W-1:0] coord_t;

  typedef enum logic [1:0] {C_RED, C_GREEN, C_BLUE, C_YELLOW} color_e;

  // One bit per channel; expanded to full scale at the output register.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_mask_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           dx;
    logic           dy;
  } sq_state_t;

  function automatic rgb_mask_t color_mask(input int idx);
    rgb_mask_t m;
    color_e    c;
    m = '0;
    c = color_e'(2'(idx % 4));
    case (c)
      C_RED:    m.r = 1'b1;
      C_GREEN:  m.g = 1'b1;
      C_BLUE:   m.b = 1'b1;
      C_YELLOW: begin m.r = 1'b1; m.g = 1'b1; end
      default:  m = '0;
    endcase
    return m;
  endfunction

  function automatic int start_x(input int idx);
    return 120 + 80 * idx;
  endfunction

  function automatic int start_y(input int idx);
    return 40 + 80 * idx;
  endfunction

endpackage

// File: rtl/square_animator_if.sv
// Pixel-side bundle between the VGA timing generator and the square animator.
interface square_animator_if
  import square_animator_pkg::*;
#(
  parameter int COLOR_W = 4
) ();
  logic               i_pix_stb;
  logic [X_W-1:0]     i_x;
  logic [Y_W-1:0]     i_y;
  logic               i_blank;
  logic               i_animate;
  logic               i_enable;
  logic               i_blend;
  logic [COLOR_W-1:0] o_r;
  logic [COLOR_W-1:0] o_g;
  logic [COLOR_W-1:0] o_b;
  logic               o_collide;

  modport master (
    output i_pix_stb, i_x, i_y, i_blank, i_animate, i_enable, i_blend,
    input  o_r, o_g, o_b, o_collide
  );

  modport slave (
    input  i_pix_stb, i_x, i_y, i_blank, i_animate, i_enable, i_blend,
    output o_r, o_g, o_b, o_collide
  );
endinterface

// File: rtl/square_animator_mover.sv
// One bouncing square: position/direction registers, edge bounce and the
// per-pixel hit test.
module square_mover
  import square_animator_pkg::*;
#(
  parameter int   SQ_SIZE  = 64,
  parameter int   SPEED    = 2,
  parameter int   START_X  = 120,
  parameter int   START_Y  = 40,
  parameter logic START_DX = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           move,
  input  logic [X_W-1:0] px,
  input  logic [Y_W-1:0] py,
  output logic           hit
);
  localparam coord_t X_MAX = coord_t'(H_RES - SQ_SIZE);
  localparam coord_t Y_MAX = coord_t'(V_RES - SQ_SIZE);
  localparam coord_t SPD   = coord_t'(SPEED);
  localparam coord_t SQ    = coord_t'(SQ_SIZE);
  localparam sq_state_t RST = '{x: X_W'(START_X), y: Y_W'(START_Y),
                                dx: START_DX, dy: 1'b1};

  sq_state_t st, st_nx;
  coord_t    xc, yc, pxc, pyc, nx, ny;
  logic      ndx, ndy;

  assign xc  = coord_t'(st.x);
  assign yc  = coord_t'(st.y);
  assign pxc = coord_t'(px);
  assign pyc = coord_t'(py);

  // Clamp to the edge and reverse rather than overshoot.
  function automatic void step_axis(input coord_t p, input logic d, input coord_t pmax,
                                    output coord_t np, output logic nd);
    np = p;
    nd = d;
    if (d) begin
      if (p + SPD > pmax) begin np = pmax; nd = 1'b0; end
      else                  np = p + SPD;
    end else begin
      if (p < SPD) begin np = '0; nd = 1'b1; end
      else           np = p - SPD;
    end
  endfunction

  always_comb begin
    nx  = xc;
    ny  = yc;
    ndx = st.dx;
    ndy = st.dy;
    step_axis(xc, st.dx, X_MAX, nx, ndx);
    step_axis(yc, st.dy, Y_MAX, ny, ndy);
    st_nx = '{x: X_W'(nx), y: Y_W'(ny), dx: ndx, dy: ndy};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    st <= RST;
    else if (move) st <= st_nx;
  end

  assign hit = (pxc >= xc) && (pxc < xc + SQ) && (pyc >= yc) && (pyc < yc + SQ);

endmodule

// File: rtl/square_animator.sv
// N_SQ bouncing squares composited per pixel (priority or OR-blend) into
// registered RGB, plus a per-frame overlap flag.
module square_animator
  import square_animator_pkg::*;
#(
  parameter int N_SQ    = 4,
  parameter int SQ_SIZE = 64,
  parameter int SPEED   = 2,
  parameter int COLOR_W = 4
) (
  input logic              i_clk,
  input logic              i_rst_n,
  square_animator_if.slave bus
);
  logic [N_SQ-1:0]    hit;
  logic               move, coll_now;
  rgb_mask_t          pri_m, or_m, px_m;
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic               acc_q, collide_q;

  assign move = bus.i_animate & bus.i_enable;

  for (genvar i = 0; i < N_SQ; i++) begin : g_sq
    square_mover #(
      .SQ_SIZE (SQ_SIZE),
      .SPEED   (SPEED),
      .START_X (start_x(i)),
      .START_Y (start_y(i)),
      .START_DX((i % 2) == 0)
    ) u_mv (
      .clk  (i_clk),
      .rst_n(i_rst_n),
      .move (move),
      .px   (bus.i_x),
      .py   (bus.i_y),
      .hit  (hit[i])
    );
  end

  // Descending scan so the lowest-index hit is the last write and wins.
  always_comb begin
    pri_m = '0;
    or_m  = '0;
    for (int i = N_SQ - 1; i >= 0; i--) if (hit[i]) pri_m = color_mask(i);
    for (int i = 0; i < N_SQ; i++)      if (hit[i]) or_m  = or_m | color_mask(i);
    if (bus.i_blank)      px_m = '0;
    else if (bus.i_blend) px_m = or_m;
    else                  px_m = pri_m;
  end

  assign coll_now = bus.i_pix_stb & ~bus.i_blank & ($countones(hit) >= 2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (bus.i_pix_stb) begin
      r_q <= {COLOR_W{px_m.r}};
      g_q <= {COLOR_W{px_m.g}};
      b_q <= {COLOR_W{px_m.b}};
    end
  end

  // The animate pulse closes the frame: the pixel seen in that same cycle
  // still counts toward the frame being reported.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q     <= 1'b0;
      collide_q <= 1'b0;
    end else if (bus.i_animate) begin
      collide_q <= acc_q | coll_now;
      acc_q     <= 1'b0;
    end else if (coll_now) begin
      acc_q     <= 1'b1;
    end
  end

  assign bus.o_r       = r_q;
  assign bus.o_g       = g_q;
  assign bus.o_b       = b_q;
  assign bus.o_collide = collide_q;

endmodule

// File: tb/tb_square_animator.sv
// Randomised scoreboard bench for square_animator against a geometric model
// of the bouncing squares.
module tb_square_animator;
  localparam int N_SQ = 4;
  localparam int SQ   = 64;
  localparam int SPD  = 2;
  localparam int CW   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  square_animator_if #(.COLOR_W(CW)) bus ();

  square_animator #(.N_SQ(N_SQ), .SQ_SIZE(SQ), .SPEED(SPD), .COLOR_W(CW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  int mx[N_SQ];
  int my[N_SQ];
  bit mdx[N_SQ];
  bit mdy[N_SQ];
  bit macc;

  logic [11:0] q_rgb[$];
  bit          q_col[$];

  function automatic logic [11:0] pal(input int i);
    case (i % 4)
      0:       return 12'hF00;
      1:       return 12'h0F0;
      2:       return 12'h00F;
      default: return 12'hFF0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N_SQ; i++) begin
      mx[i]  = 120 + 80 * i;
      my[i]  = 40 + 80 * i;
      mdx[i] = (i % 2) == 0;
      mdy[i] = 1'b1;
    end
    macc = 1'b0;
  endfunction

  function automatic bit inside_sq(input int i, input int x, input int y);
    return x >= mx[i] && x < mx[i] + SQ && y >= my[i] && y < my[i] + SQ;
  endfunction

  function automatic int nhits(input int x, input int y);
    int n = 0;
    for (int i = 0; i < N_SQ; i++) if (inside_sq(i, x, y)) n++;
    return n;
  endfunction

  function automatic logic [11:0] exp_color(input int x, input int y, input bit blank,
                                            input bit blend);
    logic [11:0] c = 12'h000;
    bit found = 1'b0;
    if (blank) return 12'h000;
    for (int i = 0; i < N_SQ; i++) begin
      if (inside_sq(i, x, y)) begin
        if (blend) c = c | pal(i);
        else if (!found) begin c = pal(i); found = 1'b1; end
      end
    end
    return c;
  endfunction

  // Travel SPD along the current direction; a square that would leave the
  // screen lands on the edge and turns around.
  function automatic void move_axis(input int p, input bit d, input int lim,
                                    output int np, output bit nd);
    int t;
    t  = d ? p + SPD : p - SPD;
    np = t;
    nd = d;
    if (t > lim) begin np = lim; nd = 1'b0; end
    if (t < 0)   begin np = 0;   nd = 1'b1; end
  endfunction

  function automatic void model_move();
    int  np;
    bit  nd;
    for (int i = 0; i < N_SQ; i++) begin
      move_axis(mx[i], mdx[i], 640 - SQ, np, nd); mx[i] = np; mdx[i] = nd;
      move_axis(my[i], mdy[i], 480 - SQ, np, nd); my[i] = np; mdy[i] = nd;
    end
  endfunction

  task automatic step(input bit stb, input int x, input int y, input bit blank,
                      input bit anim, input bit en, input bit blend);
    bit coll_now;
    @(negedge clk);
    bus.i_pix_stb = stb;
    bus.i_x       = 10'(x);
    bus.i_y       = 9'(y);
    bus.i_blank   = blank;
    bus.i_animate = anim;
    bus.i_enable  = en;
    bus.i_blend   = blend;
    coll_now = stb && !blank && (nhits(x, y) >= 2);
    if (stb) q_rgb.push_back(exp_color(x, y, blank, blend));
    if (anim) begin
      q_col.push_back(macc | coll_now);
      macc = 1'b0;
      if (en) model_move();
    end else if (coll_now) begin
      macc = 1'b1;
    end
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Half uniform, half clustered on a square's edges so bounces and
  // overlaps are actually observed.
  function automatic void pick(output int x, output int y);
    int k;
    if ($urandom_range(0, 1) == 0) begin
      x = $urandom_range(0, 639);
      y = $urandom_range(0, 479);
    end else begin
      k = $urandom_range(0, N_SQ - 1);
      x = mx[k] + $urandom_range(0, SQ + 1) - 1;
      y = my[k] + $urandom_range(0, SQ + 1) - 1;
      if (x < 0) x = 0;
      if (x > 639) x = 639;
      if (y < 0) y = 0;
      if (y > 479) y = 479;
    end
  endfunction

  task automatic check_out_zero(input string tag);
    checks++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== 12'h000 || bus.o_collide !== 1'b0) begin
      errors++;
      $display("FAIL %s rgb=%h collide=%b expected rgb=000 collide=0", tag,
               {bus.o_r, bus.o_g, bus.o_b}, bus.o_collide);
    end
  endtask

  // Monitor: the cycle after a strobe/animate the DUT presents its answer.
  always @(posedge clk) begin
    bit s, a, r;
    logic [11:0] e;
    bit ec;
    s = bus.i_pix_stb;
    a = bus.i_animate;
    r = rst_n;
    #1;
    if (r && s) begin
      checks++;
      if (q_rgb.size() == 0) begin
        errors++;
        $display("FAIL rgb_queue got %h expected nothing pending", {bus.o_r, bus.o_g, bus.o_b});
      end else begin
        e = q_rgb.pop_front();
        if ({bus.o_r, bus.o_g, bus.o_b} !== e) begin
          errors++;
          $display("FAIL rgb at t=%0t got %h expected %h", $time, {bus.o_r, bus.o_g, bus.o_b}, e);
        end
      end
    end
    if (r && a) begin
      checks++;
      if (q_col.size() == 0) begin
        errors++;
        $display("FAIL collide_queue got %b expected nothing pending", bus.o_collide);
      end else begin
        ec = q_col.pop_front();
        if (bus.o_collide !== ec) begin
          errors++;
          $display("FAIL collide at t=%0t got %b expected %b", $time, bus.o_collide, ec);
        end
      end
    end
  end

  initial begin
    int x, y, npix;
    bit en;
    model_reset();
    bus.i_pix_stb = 1'b0;
    bus.i_x       = '0;
    bus.i_y       = '0;
    bus.i_blank   = 1'b0;
    bus.i_animate = 1'b0;
    bus.i_enable  = 1'b1;
    bus.i_blend   = 1'b0;

    repeat (3) @(negedge clk);
    #1 check_out_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed composite and edge probes on the reset layout.
    step(1'b1, 250, 150, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 250, 150, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 250, 150, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 120, 40, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 119, 40, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 183, 103, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 184, 103, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 200, 120, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();

    for (int f = 0; f < 600; f++) begin
      npix = $urandom_range(8, 20);
      for (int p = 0; p < npix; p++) begin
        if (f == 303 && p == 3) begin
          idle();
          @(negedge clk);
          rst_n = 1'b0;
          #1 check_out_zero("midframe_reset");
          model_reset();
          repeat (2) @(negedge clk);
          check_out_zero("reset_held");
          rst_n = 1'b1;
        end
        pick(x, y);
        step(1'b1, x, y, $urandom_range(0, 7) == 0, 1'b0, 1'b1, $urandom_range(0, 1) == 1);
        repeat ($urandom_range(0, 2)) idle();
      end
      en = (f >= 200 && f < 210) ? 1'b0 : ($urandom_range(0, 15) != 0);
      pick(x, y);
      step($urandom_range(0, 1) == 1, x, y, 1'b0, 1'b1, en, $urandom_range(0, 1) == 1);
      idle();
    end

    repeat (3) idle();
    checks++;
    if (q_rgb.size() != 0 || q_col.size() != 0) begin
      errors++;
      $display("FAIL drain rgb_left=%0d collide_left=%0d expected 0 and 0",
               q_rgb.size(), q_col.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
